// File: rtl/raster_pkg.sv
// Shared types and constants for the raster engines: coordinate/error widths,
// default screen geometry and the FSM state encoding.
package raster_pkg;
    localparam int COORD_W      = 11;
    localparam int ERR_W        = 13;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [ERR_W-1:0] err_t;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_DRAW  = 3'd2;
    localparam state_t ST_CLEAR = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: from the current error term and position,
// produce the next error and position. Both axis decisions use the incoming err.
module bresenham_step
    import raster_pkg::*;
(
    input  err_t   err_i,
    input  err_t   dx_i,
    input  err_t   dy_i,
    input  logic   sx_neg_i,
    input  logic   sy_neg_i,
    input  coord_t cx_i,
    input  coord_t cy_i,
    output err_t   err_o,
    output coord_t cx_o,
    output coord_t cy_o
);
    logic signed [ERR_W:0] e2;
    logic signed [ERR_W:0] dx_ext;
    logic signed [ERR_W:0] dy_ext;
    logic                  step_x;
    logic                  step_y;
    err_t                  err_x;

    always_comb begin
        // One extra bit so 2*err cannot overflow.
        e2     = {err_i, 1'b0};
        dx_ext = {dx_i[ERR_W-1], dx_i};
        dy_ext = {dy_i[ERR_W-1], dy_i};
        step_x = (e2 >= dy_ext);
        step_y = (e2 <= dx_ext);
        err_x  = step_x ? err_i + dy_i : err_i;
        err_o  = step_y ? err_x + dx_i : err_x;
        cx_o   = cx_i;
        cy_o   = cy_i;
        if (step_x) cx_o = sx_neg_i ? cx_i - coord_t'(1) : cx_i + coord_t'(1);
        if (step_y) cy_o = sy_neg_i ? cy_i - coord_t'(1) : cy_i + coord_t'(1);
    end
endmodule

// File: rtl/line_raster.sv
// Line / clear-screen rasterizer: one framebuffer write per cycle, lines clipped
// to the visible screen, start accepted only when idle (never queued).
module line_raster
    import raster_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               start,
    input  logic               cmd,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               color,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pixel_color,
    output logic               pixel_write
);
    localparam logic [COORD_W:0] W_LIM  = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] H_LIM  = (COORD_W+1)'(SCREEN_H);
    localparam coord_t           W_LAST = coord_t'(SCREEN_W - 1);
    localparam coord_t           H_LAST = coord_t'(SCREEN_H - 1);

    state_t state_q, state_d;
    coord_t cx_q, cx_d, cy_q, cy_d;
    coord_t x1_q, x1_d, y1_q, y1_d;
    err_t   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic   sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic   color_q, color_d;

    coord_t dx_abs, dy_abs;
    err_t   step_err;
    coord_t step_cx, step_cy;
    logic   in_view;

    bresenham_step u_step (
        .err_i    (err_q),
        .dx_i     (dx_q),
        .dy_i     (dy_q),
        .sx_neg_i (sx_neg_q),
        .sy_neg_i (sy_neg_q),
        .cx_i     (cx_q),
        .cy_i     (cy_q),
        .err_o    (step_err),
        .cx_o     (step_cx),
        .cy_o     (step_cy)
    );

    always_comb begin
        dx_abs   = (x1_q >= cx_q) ? x1_q - cx_q : cx_q - x1_q;
        dy_abs   = (y1_q >= cy_q) ? y1_q - cy_q : cy_q - y1_q;
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        color_d  = color_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    color_d = color;
                    x1_d    = x1;
                    y1_d    = y1;
                    if (cmd) begin
                        cx_d    = '0;
                        cy_d    = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        cx_d    = x0;
                        cy_d    = y0;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                sx_neg_d = (x1_q < cx_q);
                sy_neg_d = (y1_q < cy_q);
                dx_d     = {2'b00, dx_abs};
                dy_d     = '0 - {2'b00, dy_abs};
                err_d    = {2'b00, dx_abs} - {2'b00, dy_abs};
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                if (cx_q == x1_q && cy_q == y1_q) begin
                    state_d = ST_DONE;
                end else begin
                    err_d = step_err;
                    cx_d  = step_cx;
                    cy_d  = step_cy;
                end
            end
            ST_CLEAR: begin
                if (cx_q == W_LAST) begin
                    cx_d = '0;
                    if (cy_q == H_LAST) state_d = ST_DONE;
                    else                cy_d    = cy_q + coord_t'(1);
                end else begin
                    cx_d = cx_q + coord_t'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            color_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            color_q  <= color_d;
        end
    end

    // Outputs decode straight from state so a reset silences writes at once.
    assign in_view     = ({1'b0, cx_q} < W_LIM) && ({1'b0, cy_q} < H_LIM);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign x           = cx_q;
    assign y           = cy_q;
    assign pixel_color = color_q;
    assign pixel_write = ((state_q == ST_DRAW) && in_view) || (state_q == ST_CLEAR);
endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster; screen height is reduced to 48 lines so the
// full-screen clear stays short while width 640 keeps the clipping case intact.
module tb_line_raster;
    localparam int TW = 640;
    localparam int TH = 48;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cmd   = 1'b0;
    logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic        color = 1'b0;
    logic        busy, done, pixel_color, pixel_write;
    logic [10:0] x, y;

    int cmp_n = 0;
    int err_n = 0;

    int wx[$], wy[$], wc[$], wk[$];
    int done_k;

    line_raster #(.SCREEN_W(TW), .SCREEN_H(TH)) dut (
        .clk50       (clk50),
        .reset       (reset),
        .start       (start),
        .cmd         (cmd),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .color       (color),
        .busy        (busy),
        .done        (done),
        .x           (x),
        .y           (y),
        .pixel_color (pixel_color),
        .pixel_write (pixel_write)
    );

    always #10 clk50 = ~clk50;

    // k counts cycles after the start edge: k=1 is the cycle after acceptance.
    task automatic run_cmd(input logic c, input int ax0, input int ay0, input int ax1,
                           input int ay1, input logic col, input int budget, input int poke_k);
        wx.delete(); wy.delete(); wc.delete(); wk.delete();
        done_k = -1;
        @(negedge clk50);
        cmd = c; color = col; start = 1'b1;
        x0 = 11'(ax0); y0 = 11'(ay0); x1 = 11'(ax1); y1 = 11'(ay1);
        @(negedge clk50);
        start = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk50);
            start = 1'b0;
            if (pixel_write) begin
                wx.push_back(int'(x)); wy.push_back(int'(y));
                wc.push_back(int'(pixel_color)); wk.push_back(k);
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (k == poke_k) begin
                start = 1'b1; cmd = 1'b1;
                x0 = 11'd0; y0 = 11'd0; x1 = 11'd0; y1 = 11'd0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk50);
        cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL reset_busy got %0b want 0", busy); end
        cmp_n++; if (done !== 1'b0) begin err_n++; $display("FAIL reset_done got %0b want 0", done); end
        cmp_n++; if (pixel_write !== 1'b0) begin err_n++; $display("FAIL reset_pw got %0b want 0", pixel_write); end
        cmp_n++; if (x !== 11'd0 || y !== 11'd0) begin err_n++; $display("FAIL reset_xy got (%0d,%0d) want (0,0)", x, y); end
        cmp_n++; if (pixel_color !== 1'b0) begin err_n++; $display("FAIL reset_color got %0b want 0", pixel_color); end
        reset = 1'b0;
    endtask

    task automatic test_horizontal();
        run_cmd(1'b0, 10, 5, 14, 5, 1'b1, 50, 0);
        cmp_n++; if (wx.size() != 5) begin err_n++; $display("FAIL horiz_count got %0d want 5", wx.size()); end
        else for (int i = 0; i < 5; i++) begin
            cmp_n++;
            if (wx[i] !== 10 + i || wy[i] !== 5 || wc[i] !== 1 || wk[i] !== 2 + i) begin
                err_n++;
                $display("FAIL horiz_px%0d got (%0d,%0d) c%0d k%0d want (%0d,5) c1 k%0d", i, wx[i], wy[i], wc[i], wk[i], 10 + i, 2 + i);
            end
        end
        cmp_n++; if (done_k !== 7) begin err_n++; $display("FAIL horiz_done got k%0d want k7", done_k); end
        @(negedge clk50);
        cmp_n++; if (done !== 1'b0 || busy !== 1'b0) begin err_n++; $display("FAIL horiz_after got done%0b busy%0b want 0 0", done, busy); end
    endtask

    task automatic test_reverse_and_steep();
        int ex[5];
        int ey[5];
        run_cmd(1'b0, 14, 5, 10, 5, 1'b0, 50, 0);
        cmp_n++; if (wx.size() != 5) begin err_n++; $display("FAIL rev_count got %0d want 5", wx.size()); end
        else for (int i = 0; i < 5; i++) begin
            cmp_n++;
            if (wx[i] !== 14 - i || wy[i] !== 5 || wc[i] !== 0) begin
                err_n++; $display("FAIL rev_px%0d got (%0d,%0d) c%0d want (%0d,5) c0", i, wx[i], wy[i], wc[i], 14 - i);
            end
        end
        ex = '{0, 0, 1, 1, 1};
        ey = '{0, 1, 2, 3, 4};
        run_cmd(1'b0, 0, 0, 1, 4, 1'b1, 50, 0);
        cmp_n++; if (wx.size() != 5) begin err_n++; $display("FAIL steep_count got %0d want 5", wx.size()); end
        else for (int i = 0; i < 5; i++) begin
            cmp_n++;
            if (wx[i] !== ex[i] || wy[i] !== ey[i]) begin
                err_n++; $display("FAIL steep_px%0d got (%0d,%0d) want (%0d,%0d)", i, wx[i], wy[i], ex[i], ey[i]);
            end
        end
        cmp_n++; if (done_k !== 7) begin err_n++; $display("FAIL steep_done got k%0d want k7", done_k); end
    endtask

    task automatic test_point_and_busy_start();
        run_cmd(1'b0, 7, 7, 7, 7, 1'b1, 20, 0);
        cmp_n++;
        if (wx.size() != 1 || wx[0] !== 7 || wy[0] !== 7 || wk[0] !== 2) begin
            err_n++; $display("FAIL point_px got %0d writes first (%0d,%0d) k%0d want 1 write (7,7) k2",
                              wx.size(), (wx.size() > 0) ? wx[0] : -1, (wy.size() > 0) ? wy[0] : -1, (wk.size() > 0) ? wk[0] : -1);
        end
        cmp_n++; if (done_k !== 3) begin err_n++; $display("FAIL point_done got k%0d want k3", done_k); end
        // A clear command poked mid-line must be dropped.
        run_cmd(1'b0, 10, 5, 14, 5, 1'b1, 50, 3);
        cmp_n++; if (wx.size() != 5 || done_k !== 7) begin err_n++; $display("FAIL busy_start_line got %0d writes done k%0d want 5 k7", wx.size(), done_k); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50);
            cmp_n++; if (busy !== 1'b0 || pixel_write !== 1'b0) begin err_n++; $display("FAIL busy_start_idle%0d got busy%0b pw%0b want 0 0", i, busy, pixel_write); end
        end
    endtask

    task automatic test_clip();
        run_cmd(1'b0, 635, 0, 644, 0, 1'b1, 50, 0);
        cmp_n++; if (done_k !== 12) begin err_n++; $display("FAIL clip_cycles got done k%0d want k12", done_k); end
        cmp_n++; if (wx.size() != 5) begin err_n++; $display("FAIL clip_count got %0d want 5", wx.size()); end
        else for (int i = 0; i < 5; i++) begin
            cmp_n++;
            if (wx[i] !== 635 + i || wk[i] !== 2 + i) begin
                err_n++; $display("FAIL clip_px%0d got x%0d k%0d want x%0d k%0d", i, wx[i], wk[i], 635 + i, 2 + i);
            end
        end
    endtask

    task automatic test_clear();
        int bad;
        int n;
        bad = 0;
        run_cmd(1'b1, 0, 0, 0, 0, 1'b0, TW * TH + 100, 0);
        n = wx.size();
        cmp_n++; if (n != TW * TH) begin err_n++; $display("FAIL clear_count got %0d want %0d", n, TW * TH); end
        for (int i = 0; i < n; i++)
            if (wx[i] !== i % TW || wy[i] !== i / TW || wc[i] !== 0 || wk[i] !== i + 1) bad++;
        cmp_n++; if (bad != 0) begin err_n++; $display("FAIL clear_order got %0d bad writes want 0", bad); end
        cmp_n++;
        if (n == 0 || wx[n-1] !== TW - 1 || wy[n-1] !== TH - 1 || done_k !== wk[n-1] + 1) begin
            err_n++; $display("FAIL clear_last got (%0d,%0d) done k%0d want (%0d,%0d) done one after last",
                              (n > 0) ? wx[n-1] : -1, (n > 0) ? wy[n-1] : -1, done_k, TW - 1, TH - 1);
        end
    endtask

    task automatic test_reset_mid_line();
        int extra;
        extra = 0;
        @(negedge clk50);
        cmd = 1'b0; color = 1'b1; start = 1'b1;
        x0 = 11'd0; y0 = 11'd0; x1 = 11'd100; y1 = 11'd0;
        @(negedge clk50);
        start = 1'b0;
        repeat (8) @(negedge clk50);
        cmp_n++; if (pixel_write !== 1'b1) begin err_n++; $display("FAIL midreset_pre got pw%0b want 1", pixel_write); end
        reset = 1'b1;
        #1;
        cmp_n++;
        if (pixel_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            err_n++; $display("FAIL midreset_now got pw%0b busy%0b done%0b want 0 0 0", pixel_write, busy, done);
        end
        @(negedge clk50);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk50);
            if (pixel_write || done || busy) extra++;
        end
        cmp_n++; if (extra != 0) begin err_n++; $display("FAIL midreset_quiet got %0d active cycles want 0", extra); end
        run_cmd(1'b0, 3, 3, 5, 3, 1'b1, 50, 0);
        cmp_n++;
        if (wx.size() != 3 || done_k !== 5) begin
            err_n++; $display("FAIL midreset_redraw got %0d writes done k%0d want 3 k5", wx.size(), done_k);
        end else if (wx[0] !== 3 || wx[2] !== 5 || wy[1] !== 3) begin
            err_n++; $display("FAIL midreset_redraw got x%0d..x%0d y%0d want x3..x5 y3", wx[0], wx[2], wy[1]);
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_reverse_and_steep();
        test_point_and_busy_start();
        test_clip();
        test_clear();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
